// File: rtl/final_phase_pack_if.sv
// Operand/result bundle between the normalization stage and the final pack stage.
// rnd_mode exists only when PACK_RND_MODE_EN is defined.
interface final_phase_pack_if #(
  parameter int W  = 32,
  parameter int EW = 8,
  parameter int SW = 23
);
  logic          start;
  logic          zero_in;
  logic          sign_in;
  logic [EW:0]   exp_in;
  logic [SW+3:0] mant_in;
`ifdef PACK_RND_MODE_EN
  logic [1:0]    rnd_mode;
`endif
  logic          busy;
  logic          ready;
  logic [W-1:0]  result;
  logic          overflow_flag;
  logic          underflow_flag;

  modport master (
`ifdef PACK_RND_MODE_EN
    output rnd_mode,
`endif
    output start, zero_in, sign_in, exp_in, mant_in,
    input  busy, ready, result, overflow_flag, underflow_flag
  );

  modport slave (
`ifdef PACK_RND_MODE_EN
    input  rnd_mode,
`endif
    input  start, zero_in, sign_in, exp_in, mant_in,
    output busy, ready, result, overflow_flag, underflow_flag
  );
endinterface

// File: rtl/final_phase_pack.sv
// Rounding, carry adjust and IEEE 754 packing back end of the FP add/sub datapath.
// Optional directed rounding modes are enabled by defining PACK_RND_MODE_EN.
module final_phase_pack #(
  parameter int W  = 32,
  parameter int EW = 8,
  parameter int SW = 23
) (
  input logic               clk,
  input logic               rst,
  final_phase_pack_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUND  = 2'd1,
    ADJUST = 2'd2,
    PACK   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          sign_q, sign_d;
  logic          zero_q, zero_d;
  logic [EW:0]   exp_q, exp_d;
  logic [SW+3:0] mant_q, mant_d;
  logic [SW+1:0] rsum_q, rsum_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;
  logic [W-1:0]  result_q, result_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          inc_s;
  logic          sat_s;
`ifdef PACK_RND_MODE_EN
  logic [1:0]    rnd_q, rnd_d;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      exp_q    <= {(EW+1){1'b0}};
      mant_q   <= {(SW+4){1'b0}};
      rsum_q   <= {(SW+2){1'b0}};
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= {W{1'b0}};
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
`ifdef PACK_RND_MODE_EN
      rnd_q    <= 2'b00;
`endif
    end else begin
      sign_q   <= sign_d;
      zero_q   <= zero_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      rsum_q   <= rsum_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
`ifdef PACK_RND_MODE_EN
      rnd_q    <= rnd_d;
`endif
    end
  end

  // Next-state sequencing: fixed IDLE -> ROUND -> ADJUST -> PACK walk
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ROUND;
        end else begin
          state_d = IDLE;
        end
      end
      ROUND:   state_d = ADJUST;
      ADJUST:  state_d = PACK;
      PACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Rounding increment and overflow saturation policy
  always_comb begin
    sat_s = 1'b0;
`ifdef PACK_RND_MODE_EN
    case (rnd_q)
      2'b00:   inc_s = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
      2'b01:   inc_s = 1'b0;
      2'b10:   inc_s = ~sign_q & (mant_q[2] | mant_q[1] | mant_q[0]);
      2'b11:   inc_s = sign_q & (mant_q[2] | mant_q[1] | mant_q[0]);
      default: inc_s = 1'b0;
    endcase
    sat_s = (rnd_q == 2'b01) | ((rnd_q == 2'b10) & sign_q) | ((rnd_q == 2'b11) & ~sign_q);
`else
    inc_s = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
`endif
  end

  // Per-state datapath updates and registered outputs
  always_comb begin
    sign_d   = sign_q;
    zero_d   = zero_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    rsum_d   = rsum_q;
    ready_d  = 1'b0;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
`ifdef PACK_RND_MODE_EN
    rnd_d    = rnd_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sign_d = bus.sign_in;
          zero_d = bus.zero_in;
          exp_d  = bus.exp_in;
          mant_d = bus.mant_in;
`ifdef PACK_RND_MODE_EN
          rnd_d  = bus.rnd_mode;
`endif
        end else begin
          sign_d = sign_q;
        end
      end
      ROUND: begin
        rsum_d = {1'b0, mant_q[SW+3:3]} + {{(SW+1){1'b0}}, inc_s};
      end
      ADJUST: begin
        if (rsum_q[SW+1]) begin
          rsum_d = {1'b0, rsum_q[SW+1:1]};
          // Exponent saturates rather than wrapping so a huge value stays an overflow
          if (exp_q == {(EW+1){1'b1}}) begin
            exp_d = exp_q;
          end else begin
            exp_d = exp_q + {{EW{1'b0}}, 1'b1};
          end
        end else begin
          rsum_d = rsum_q;
        end
      end
      PACK: begin
        ready_d = 1'b1;
        if (zero_q) begin
          result_d = {W{1'b0}};
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
        end else if (exp_q >= {1'b0, {EW{1'b1}}}) begin
          ovf_d = 1'b1;
          unf_d = 1'b0;
          if (sat_s) begin
            result_d = {sign_q, {(EW-1){1'b1}}, 1'b0, {SW{1'b1}}};
          end else begin
            result_d = {sign_q, {EW{1'b1}}, {SW{1'b0}}};
          end
        end else if (exp_q == {(EW+1){1'b0}}) begin
          result_d = {sign_q, {(W-1){1'b0}}};
          ovf_d    = 1'b0;
          unf_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_q[EW-1:0], rsum_q[SW-1:0]};
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
        end
      end
      default: ready_d = 1'b0;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign bus.busy           = busy_q;
  assign bus.ready          = ready_q;
  assign bus.result         = result_q;
  assign bus.overflow_flag  = ovf_q;
  assign bus.underflow_flag = unf_q;

endmodule

// File: tb/tb_final_phase_pack.sv
// Self-checking bench for final_phase_pack: directed table, reference-model random ops, control corners.
module tb_final_phase_pack;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  final_phase_pack_if #(.W(32), .EW(8), .SW(23)) bus ();
  final_phase_pack #(.W(32), .EW(8), .SW(23)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic        z;
    logic [8:0]  e;
    logic [26:0] m;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: round to nearest even by comparing the discarded tail against one half
  function automatic logic [33:0] ref_model(input logic s, input logic z,
                                            input logic [8:0] e, input logic [26:0] m);
    longint sig = longint'(m >> 3);
    int     tail = int'(m & 27'd7);
    int     ex = int'(e);
    if (z) return 34'd0;
    if (tail > 4 || (tail == 4 && (sig % 2) == 1)) sig = sig + 1;
    if (sig >= (longint'(1) << 24)) begin
      sig = sig / 2;
      ex  = (ex >= 511) ? 511 : ex + 1;
    end
    if (ex >= 255) return {1'b1, 1'b0, s, 8'hFF, 23'h0};
    if (ex == 0)   return {1'b0, 1'b1, s, 31'h0};
    return {1'b0, 1'b0, s, 8'(ex), 23'(sig)};
  endfunction

  task automatic do_op(input logic s, input logic z, input logic [8:0] e, input logic [26:0] m,
                       output logic [31:0] res, output logic ovf, output logic unf, input string nm);
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.sign_in = s; bus.zero_in = z; bus.exp_in = e; bus.mant_in = m;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.sign_in = 1'($urandom); bus.zero_in = 1'($urandom);
    bus.exp_in  = 9'($urandom); bus.mant_in = 27'($urandom);
    chk({nm, " busy"}, 64'(bus.busy), 64'd1);
    lat = 0;
    while (!bus.ready && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'd3);
    chk({nm, " busy_end"}, 64'(bus.busy), 64'd0);
    res = bus.result; ovf = bus.overflow_flag; unf = bus.underflow_flag;
  endtask

  initial begin
    logic [31:0] r;
    logic        o, u;
    logic [33:0] exp_v;
    int          pulses;

    vecs[0]  = '{1'b0, 1'b0, 9'h07F, {1'b1, 23'h000000, 3'b000}, 32'h3F800000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 9'h07F, {1'b1, 23'h000000, 3'b100}, 32'h3F800000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 9'h07F, {1'b1, 23'h000001, 3'b100}, 32'h3F800002, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 9'h07F, {1'b1, 23'h7FFFFF, 3'b110}, 32'h40000000, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 9'h0FE, {1'b1, 23'h7FFFFF, 3'b100}, 32'h7F800000, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 9'h0FE, {1'b1, 23'h7FFFFF, 3'b100}, 32'hFF800000, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 9'h000, {1'b1, 23'h000000, 3'b000}, 32'h80000000, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 9'h07F, {1'b1, 23'h123456, 3'b111}, 32'h00000000, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 9'h07F, {1'b1, 23'h000000, 3'b101}, 32'h3F800001, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 9'h07F, {1'b1, 23'h000000, 3'b011}, 32'hBF800000, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 9'h100, {1'b1, 23'h000000, 3'b000}, 32'h7F800000, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 9'h001, {1'b1, 23'h2AAAAA, 3'b010}, 32'h00AAAAAA, 1'b0, 1'b0};

    bus.start = 1'b0; bus.sign_in = 1'b0; bus.zero_in = 1'b0;
    bus.exp_in = 9'h0; bus.mant_in = 27'h0;
`ifdef PACK_RND_MODE_EN
    bus.rnd_mode = 2'b00;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy",   64'(bus.busy), 64'd0);
    chk("reset ready",  64'(bus.ready), 64'd0);
    chk("reset result", 64'(bus.result), 64'd0);
    chk("reset flags",  64'({bus.overflow_flag, bus.underflow_flag}), 64'd0);
    @(negedge clk); rst = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].s, vecs[i].z, vecs[i].e, vecs[i].m, r, o, u, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d result", i), 64'(r), 64'(vecs[i].res));
      chk($sformatf("vec%0d ovf", i), 64'(o), 64'(vecs[i].ovf));
      chk($sformatf("vec%0d unf", i), 64'(u), 64'(vecs[i].unf));
    end

    for (int n = 0; n < 200; n++) begin
      logic s, z;
      logic [8:0] e;
      logic [26:0] m;
      s = 1'($urandom);
      z = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 6))
        0: e = 9'h000;
        1: e = 9'h001;
        2: e = 9'h0FE;
        3: e = 9'h0FF;
        4: e = 9'h1FF;
        default: e = 9'($urandom);
      endcase
      m = 27'($urandom);
      if ($urandom_range(0, 3) != 0) m[26] = 1'b1;
      if ($urandom_range(0, 3) == 0) m[25:3] = 23'h7FFFFF;
      do_op(s, z, e, m, r, o, u, "rand");
      exp_v = ref_model(s, z, e, m);
      chk($sformatf("rand%0d word", n), {30'd0, o, u, r}, 64'(exp_v));
    end

    // Reset during ROUND aborts the operation
    @(negedge clk);
    bus.start = 1'b1; bus.sign_in = 1'b0; bus.zero_in = 1'b0;
    bus.exp_in = 9'h07F; bus.mant_in = {1'b1, 23'h000000, 3'b000};
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b0;
    #1;
    chk("abort busy",   64'(bus.busy), 64'd0);
    chk("abort ready",  64'(bus.ready), 64'd0);
    chk("abort result", 64'(bus.result), 64'd0);
    chk("abort flags",  64'({bus.overflow_flag, bus.underflow_flag}), 64'd0);
    @(negedge clk); rst = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.ready) pulses++;
    end
    chk("abort no ready", 64'(pulses), 64'd0);
    chk("abort result hold", 64'(bus.result), 64'd0);

    // A second start while busy must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.sign_in = 1'b0; bus.zero_in = 1'b0;
    bus.exp_in = 9'h080; bus.mant_in = {1'b1, 23'h400000, 3'b000};
    @(negedge clk);
    bus.start = 1'b1; bus.sign_in = 1'b1; bus.exp_in = 9'h07F;
    bus.mant_in = {1'b1, 23'h000000, 3'b000};
    @(negedge clk);
    bus.start = 1'b0;
    pulses = 0;
    r = 32'h0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.ready) begin
        pulses++;
        r = bus.result;
      end
    end
    chk("busy start pulses", 64'(pulses), 64'd1);
    chk("busy start result", 64'(r), 64'h40400000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
